// File: rtl/music_pkg.sv
// music_pkg: note codes, 100 MHz half-period table and FSM
// encoding shared by the tone sequencer and its pitch generator.
package music_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  localparam logic [5:0] NOTE_REST = 6'd0;
  localparam logic [5:0] NOTE_BASE = 6'd3;
  localparam logic [5:0] NOTE_TOP  = 6'd62;

  localparam logic [3:0] SEMI_C  = 4'd0;
  localparam logic [3:0] SEMI_CS = 4'd1;
  localparam logic [3:0] SEMI_D  = 4'd2;
  localparam logic [3:0] SEMI_DS = 4'd3;
  localparam logic [3:0] SEMI_E  = 4'd4;
  localparam logic [3:0] SEMI_F  = 4'd5;
  localparam logic [3:0] SEMI_FS = 4'd6;
  localparam logic [3:0] SEMI_G  = 4'd7;
  localparam logic [3:0] SEMI_GS = 4'd8;
  localparam logic [3:0] SEMI_A  = 4'd9;
  localparam logic [3:0] SEMI_AS = 4'd10;
  localparam logic [3:0] SEMI_B  = 4'd11;

  // Octave-0 half periods (C2..B2) in clk cycles.
  localparam logic [19:0] HALF_BASE [12] = '{
    20'd764409, 20'd721501, 20'd681013,
    20'd642797, 20'd606722, 20'd572672,
    20'd540541, 20'd510204, 20'd481579,
    20'd454545, 20'd429037, 20'd404956
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY
  } state_t;

  function automatic logic note_is_rest(
    input logic [5:0] n
  );
    return (n < NOTE_BASE) || (n > NOTE_TOP);
  endfunction

  function automatic logic [2:0] note_oct(
    input logic [5:0] m
  );
    logic [2:0] o;
    if (m >= 6'd48)      o = 3'd4;
    else if (m >= 6'd36) o = 3'd3;
    else if (m >= 6'd24) o = 3'd2;
    else if (m >= 6'd12) o = 3'd1;
    else                 o = 3'd0;
    return o;
  endfunction

  // Zero marks a rest; otherwise half period of the square wave.
  function automatic logic [19:0] note_half(
    input logic [5:0] n
  );
    logic [5:0] m;
    logic [2:0] o;
    logic [3:0] s;
    m = n - NOTE_BASE;
    o = note_oct(m);
    s = 4'(m - 6'd12 * {3'd0, o});
    if (note_is_rest(n)) return '0;
    return HALF_BASE[s] >> o;
  endfunction

endpackage

// File: rtl/music_player_tone_gen.sv
// tone_gen: decodes a note code into a half period and
// drives the square-wave speaker from a 20-bit counter.
module tone_gen
  import music_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] note,
  input  logic       load,
  input  logic       hold,
  output logic       speaker
);

  logic [19:0] half_q;
  logic [19:0] cnt_q;
  logic [19:0] cnt_nxt;
  logic [19:0] half_m1;
  logic        spk_q;

  always_comb begin
    half_m1 = half_q - 20'd1;
    cnt_nxt = cnt_q + 20'd1;
    if (cnt_q == half_m1) cnt_nxt = '0;
  end

  // The edge that brings the count to half-1 flips the output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_q <= '0;
      cnt_q  <= '0;
      spk_q  <= 1'b0;
    end else if (load) begin
      half_q <= note_half(note);
      cnt_q  <= '0;
      spk_q  <= 1'b0;
    end else if (!hold && half_q != '0) begin
      cnt_q <= cnt_nxt;
      if (cnt_nxt == half_m1) spk_q <= ~spk_q;
    end
  end

  assign speaker = spk_q & ~hold;

endmodule

// File: rtl/music_player.sv
// music_player: ROM-driven tone sequencer (IDLE/FETCH/LOAD/PLAY).
// Define MUSIC_GAP_EN to silence the last GAP_TICKS of each note.
module music_player
  import music_pkg::*;
#(
  parameter int unsigned NOTE_TICKS = 12_500_000,
  parameter int unsigned SONG_LEN   = 256,
  parameter int unsigned GAP_TICKS  = 1_250_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       restart,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_note,
  output logic       speaker,
  output logic       playing,
  output logic [5:0] cur_note
);

  localparam int unsigned TW =
    $clog2(NOTE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST =
    TW'(NOTE_TICKS - 1);
  localparam logic [7:0] ADDR_LAST =
    8'(SONG_LEN - 1);

  if (SONG_LEN < 1 || SONG_LEN > 256)
  begin : g_bad_len
    $error("SONG_LEN must be 1..256");
  end

  if (GAP_TICKS >= NOTE_TICKS)
  begin : g_bad_gap
    $error("GAP_TICKS must be < NOTE_TICKS");
  end

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] tick_q;
  logic          note_done;
  logic          load;
  logic          hold;
  logic          in_gap;
  logic          unused_rom_hi;

  assign unused_rom_hi = ^rom_note[7:6];

`ifdef MUSIC_GAP_EN
  localparam logic [TW-1:0] GAP_FIRST =
    TW'(NOTE_TICKS - GAP_TICKS);
  assign in_gap = tick_q >= GAP_FIRST;
`else
  assign in_gap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (enable) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_PLAY;
      S_PLAY:  if (note_done) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
    if (restart) state_d = S_FETCH;
    if (!enable) state_d = S_IDLE;
  end

  always_comb begin
    load      = 1'b0;
    hold      = 1'b1;
    note_done = 1'b0;
    unique case (1'b1)
      state_q == S_LOAD:
        load = enable && !restart;
      state_q == S_PLAY: begin
        hold      = in_gap;
        note_done = tick_q == TICK_LAST;
      end
      default: ;
    endcase
  end

  // A paused end-of-note keeps the address so the note replays.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr <= '0;
      cur_note <= NOTE_REST;
      playing  <= 1'b0;
      tick_q   <= '0;
    end else begin
      playing <= state_d == S_PLAY;
      if (restart) begin
        rom_addr <= '0;
      end else if (enable && note_done) begin
        if (rom_addr < ADDR_LAST)
          rom_addr <= rom_addr + 8'd1;
        else
          rom_addr <= '0;
      end
      if (load) begin
        cur_note <= rom_note[5:0];
        tick_q   <= '0;
      end else if (state_q == S_PLAY) begin
        tick_q <= tick_q + TW'(1);
      end
    end
  end

  tone_gen u_tone (
    .clk     (clk),
    .rst_n   (rst_n),
    .note    (rom_note[5:0]),
    .load    (load),
    .hold    (hold),
    .speaker (speaker)
  );

endmodule
